// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - RLE types and default widths shared by the encoder and decoder
package rle_pkg;

  localparam int RLE_CW = 8;
  localparam int RLE_DW = 8;

  typedef struct packed {
    logic [RLE_CW-1:0] cnt;
    logic [RLE_DW-1:0] dat;
  } rle_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rle_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - stream bundle; modport d receives beats, modport s sends them
interface axi4_stream_if #(
  parameter int DN = 1,
  parameter int W  = 8
) (
  input logic ACLK,
  input logic ARESETn
);

  localparam int KW = (DN * W + 7) / 8;

  logic              TVALID;
  logic              TREADY;
  logic              TLAST;
  logic [DN*W-1:0]   TDATA;
  logic [KW-1:0]     TKEEP;

  modport d (input ACLK, ARESETn, TVALID, TDATA, TKEEP, TLAST, output TREADY);
  modport s (input ACLK, ARESETn, TREADY, output TVALID, TDATA, TKEEP, TLAST);

endinterface

// File: rtl/rle_dec.sv
// rtl/rle_dec.sv - run-length decoder: beat {cnt,dat} becomes cnt+1 samples of dat
// RLE_DEC_STS_EN adds the sts_smp output-sample counter; otherwise sts_smp reads 0.
module rle_dec
  import rle_pkg::*;
#(
  parameter int DN = 1,
  parameter int CW = RLE_CW,
  parameter int DW = RLE_DW
) (
  axi4_stream_if.d    sti,
  axi4_stream_if.s    sto,
  input  logic        ctl_rst,
  input  logic        cfg_ena,
  output logic        sts_bsy,
  output logic [31:0] sts_smp
);

  localparam int BW = CW + DW;

  rle_state_t    state_q, state_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          lst_q, lst_d;

  logic [CW-1:0] in_cnt;
  logic [DW-1:0] in_dat;
  logic          in_rdy;
  logic          in_hs;
  logic          out_hs;

  assign {in_cnt, in_dat} = sti.TDATA[DN*BW-1 -: BW];

  // A new beat may load in the same cycle the final sample of the current run leaves.
  assign in_rdy  = sti.ARESETn & ((state_q == ST_IDLE) | (sto.TREADY & (rem_q == '0)));
  assign in_hs   = sti.TVALID & in_rdy;
  assign out_hs  = (state_q == ST_RUN) & sto.TREADY;

  assign sti.TREADY = in_rdy;
  assign sto.TVALID = (state_q == ST_RUN);
  assign sto.TDATA  = dat_q;
  assign sto.TLAST  = (state_q == ST_RUN) & lst_q & (rem_q == '0);
  assign sto.TKEEP  = '1;
  assign sts_bsy    = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    rem_d   = rem_q;
    lst_d   = lst_q;
    if (in_hs) begin
      state_d = ST_RUN;
      dat_d   = in_dat;
      rem_d   = cfg_ena ? in_cnt : '0;
      lst_d   = sti.TLAST;
    end else if (out_hs) begin
      if (rem_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        rem_d = rem_q - CW'(1);
      end
    end
  end

  always_ff @(posedge sti.ACLK) begin
    if (!sti.ARESETn || ctl_rst) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      rem_q   <= '0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      rem_q   <= rem_d;
      lst_q   <= lst_d;
    end
  end

`ifdef RLE_DEC_STS_EN
  logic [31:0] smp_q, smp_d;

  assign smp_d   = out_hs ? smp_q + 32'd1 : smp_q;
  assign sts_smp = smp_q;

  always_ff @(posedge sti.ACLK) begin
    if (!sti.ARESETn || ctl_rst) begin
      smp_q <= '0;
    end else begin
      smp_q <= smp_d;
    end
  end
`else
  assign sts_smp = '0;
`endif

endmodule

// File: tb/tb_rle_dec.sv
// tb/tb_rle_dec.sv - scoreboard bench for rle_dec: directed cases then random traffic
module tb_rle_dec;
  import rle_pkg::*;

`ifdef RLE_DEC_STS_EN
  localparam bit STS_EN = 1'b1;
`else
  localparam bit STS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ctl_rst = 1'b0;
  logic        cfg_ena = 1'b1;
  logic        sts_bsy;
  logic [31:0] sts_smp;

  axi4_stream_if #(.DN(1), .W(RLE_CW + RLE_DW)) sti_if (.ACLK(clk), .ARESETn(rstn));
  axi4_stream_if #(.DN(1), .W(RLE_DW))          sto_if (.ACLK(clk), .ARESETn(rstn));

  rle_dec dut (
    .sti     (sti_if),
    .sto     (sto_if),
    .ctl_rst (ctl_rst),
    .cfg_ena (cfg_ena),
    .sts_bsy (sts_bsy),
    .sts_smp (sts_smp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int unsigned model_smp = 0;
  int out_cnt = 0;
  int rdy_mode = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output ready pattern, applied after the input driver so both settle before negedge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: sto_if.TREADY = 1'b1;
      1: sto_if.TREADY = 1'($urandom_range(0, 1));
      2: sto_if.TREADY = ~sto_if.TREADY;
      default: sto_if.TREADY = 1'b0;
    endcase
  end

  // Monitor and scoreboard: the queue holds every sample still owed by the decoder.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_sti_tready", 32'(sti_if.TREADY), 32'd0);
      exp_q.delete();
      model_smp = 0;
      prev_stall = 1'b0;
    end else begin
      chk("sto_tvalid", 32'(sto_if.TVALID), 32'(exp_q.size() != 0));
      chk("sts_bsy", 32'(sts_bsy), 32'(exp_q.size() != 0));
      chk("sti_tready", 32'(sti_if.TREADY),
          32'((exp_q.size() == 0) || (sto_if.TREADY && exp_q.size() == 1)));
      chk("sts_smp", sts_smp, STS_EN ? model_smp : 32'd0);
      if (prev_stall) begin
        chk("stall_tvalid", 32'(sto_if.TVALID), 32'd1);
        chk("stall_tdata", 32'(sto_if.TDATA), 32'(prev_data));
        chk("stall_tlast", 32'(sto_if.TLAST), 32'(prev_last));
      end
      if (sto_if.TVALID && sto_if.TREADY && !ctl_rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 32'(sto_if.TDATA), 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("sto_tdata", 32'(sto_if.TDATA), 32'(e[7:0]));
          chk("sto_tlast", 32'(sto_if.TLAST), 32'(e[8]));
        end
        model_smp++;
        out_cnt++;
      end
      prev_stall = sto_if.TVALID && !sto_if.TREADY && !ctl_rst;
      prev_data  = sto_if.TDATA;
      prev_last  = sto_if.TLAST;
      if (ctl_rst) begin
        exp_q.delete();
        model_smp = 0;
      end else if (sti_if.TVALID && sti_if.TREADY) begin
        rle_beat_t b;
        int n;
        b = sti_if.TDATA;
        n = cfg_ena ? int'(b.cnt) + 1 : 1;
        for (int i = 0; i < n; i++) begin
          exp_q.push_back({sti_if.TLAST && (i == n - 1), b.dat});
        end
      end
    end
  end

  task automatic send(input logic [7:0] cnt, input logic [7:0] dat, input logic last);
    rle_beat_t b;
    bit done = 1'b0;
    b.cnt = cnt;
    b.dat = dat;
    sti_if.TDATA  = b;
    sti_if.TLAST  = last;
    sti_if.TVALID = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = sti_if.TREADY;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    sti_if.TVALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    bit done;
    sti_if.TVALID = 1'b0;
    sti_if.TLAST  = 1'b0;
    sti_if.TDATA  = '0;
    sti_if.TKEEP  = '1;
    sto_if.TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tready_after", 32'(sti_if.TREADY), 32'd1);
    chk("rst_tvalid", 32'(sto_if.TVALID), 32'd0);
    chk("rst_tlast", 32'(sto_if.TLAST), 32'd0);
    chk("rst_bsy", 32'(sts_bsy), 32'd0);
    chk("rst_smp", sts_smp, 32'd0);
    @(posedge clk);
    #1;

    send(8'd3, 8'hA5, 1'b0);
    send(8'd0, 8'h5A, 1'b0);
    wait_idle();

    cfg_ena = 1'b0;
    send(8'd7, 8'h11, 1'b0);
    send(8'd2, 8'h22, 1'b0);
    wait_idle();
    cfg_ena = 1'b1;

    send(8'd255, 8'hFF, 1'b1);
    wait_idle();

    rdy_mode = 2;
    send(8'd2, 8'h33, 1'b0);
    wait_idle();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    base = out_cnt;
    send(8'd4, 8'h44, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      done = (out_cnt >= base + 2);
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("ctl_rst_wait_timeout", 32'd0, 32'd1);
    rdy_mode = 3;
    ctl_rst = 1'b1;
    @(posedge clk);
    #1;
    ctl_rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("ctl_rst_tvalid", 32'(sto_if.TVALID), 32'd0);
    chk("ctl_rst_bsy", 32'(sts_bsy), 32'd0);
    chk("ctl_rst_smp", sts_smp, 32'd0);
    @(posedge clk);
    #1;
    send(8'd0, 8'h77, 1'b0);
    wait_idle();

    for (int k = 0; k < 300; k++) begin
      logic [7:0] c;
      rdy_mode = int'($urandom_range(0, 1));
      cfg_ena  = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(c, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
